// File: rtl/lsu_pkg.sv
// Purpose: shared constants, encodings and types for the load/store memory port.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package lsu_pkg;

  localparam int LSU_XLEN = 32;

  // RISC-V funct3 for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // port B store-size encodings
  localparam logic [2:0] SC_NONE = 3'b000;
  localparam logic [2:0] SC_BYTE = 3'b001;
  localparam logic [2:0] SC_HALF = 3'b010;
  localparam logic [2:0] SC_WORD = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Stores only exist for B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Purpose: bundles the request/response handshakes and the port-B memory bus.
// Ports: req_* (valid/ready request), resp_* (valid/ready response), mem_* (port B).
// Modports: slave = load/store unit side, master = pipeline + memory side.
interface lsu_mem_port_if;
  import lsu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [LSU_XLEN-1:0] req_addr;
  logic [LSU_XLEN-1:0] req_wdata;

  logic                resp_valid;
  logic                resp_ready;
  logic [LSU_XLEN-1:0] resp_rdata;
  logic                resp_err;

  logic                mem_en;
  logic [LSU_XLEN-1:0] mem_addr;
  logic [LSU_XLEN-1:0] mem_din;
  logic [2:0]          storecntrl_b;
  logic [3:0]          mem_wen;
  logic [LSU_XLEN-1:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_addr, mem_din, storecntrl_b, mem_wen
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_addr, mem_din, storecntrl_b, mem_wen
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Purpose: sign/zero-extends raw load data according to funct3.
// Ports: funct3 (load type), raw (logical-order word), ext (extended result).
// Latency: combinational; no backpressure.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [LSU_XLEN-1:0] raw,
  output logic [LSU_XLEN-1:0] ext
);

  always_comb begin
    ext = '0;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   ext = {24'h0, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   ext = {16'h0, raw[15:0]};
      F3_W:    ext = raw;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Purpose: single-outstanding load/store unit driving memory port B.
// Latency: accept->resp_valid is 2 cycles for loads, 1 for stores/illegal requests.
// Backpressure: req_ready drops while a load is in flight or a response is held unconsumed.
// Ports: clk, rst_n (async active-low), bus (lsu_mem_port_if.slave: req/resp handshakes + port B).
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
)(
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_port_if.slave     bus
);

  lsu_state_t      state_q, state_d;
  logic [2:0]      ld_funct3_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            req_ready;
  logic            accept;
  logic            legal;
  logic            store_go;
  logic [2:0]      sc;
  logic [3:0]      lmask;
  logic [7:0]      wen_rot;
  logic [XLEN-1:0] ext_data;

  always_comb legal = f3_legal(bus.req_we, bus.req_funct3);

  // A held response frees the slot in the same cycle it is consumed.
  always_comb begin
    req_ready = 1'b0;
    if (state_q == IDLE) req_ready = 1'b1;
    if (state_q == RESP && bus.resp_ready) req_ready = 1'b1;
  end

  assign accept   = bus.req_valid & req_ready;
  assign store_go = accept & legal & bus.req_we;

  always_comb begin
    sc    = SC_NONE;
    lmask = 4'b0000;
    case (bus.req_funct3)
      F3_B:    begin sc = SC_BYTE; lmask = 4'b0001; end
      F3_H:    begin sc = SC_HALF; lmask = 4'b0011; end
      F3_W:    begin sc = SC_WORD; lmask = 4'b1111; end
      default: begin sc = SC_NONE; lmask = 4'b0000; end
    endcase
  end

  // 4-bit rotate-left: shift the doubled mask and keep the upper nibble.
  assign wen_rot = {lmask, lmask} << bus.req_addr[1:0];

  assign bus.req_ready    = req_ready;
  assign bus.mem_en       = accept & legal;
  assign bus.mem_addr     = bus.req_addr;
  assign bus.mem_din      = bus.req_wdata;
  assign bus.storecntrl_b = store_go ? sc : SC_NONE;
  assign bus.mem_wen      = store_go ? wen_rot[7:4] : 4'b0000;

  lsu_load_extend u_ext (
    .funct3 (ld_funct3_q),
    .raw    (bus.mem_dout),
    .ext    (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (legal && !bus.req_we) ? RD : RESP;
      RD:   state_d = RESP;
      RESP: begin
        if (accept)              state_d = (legal && !bus.req_we) ? RD : RESP;
        else if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stores and illegal requests answer straight from the accept edge;
  // loads overwrite the response with extended data when leaving RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_funct3_q <= 3'b000;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      ld_funct3_q <= bus.req_funct3;
      rdata_q     <= '0;
      err_q       <= ~legal;
    end else if (state_q == RD) begin
      rdata_q     <= ext_data;
      err_q       <= 1'b0;
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Purpose: directed + randomized self-checking bench for lsu_mem_port.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low for random stretches.
module tb_lsu_mem_port;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  lsu_mem_port_if bus();

  lsu_mem_port #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
  endtask

  // Reference rules, written from the architectural definition of each access.
  function automatic logic ref_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 < 3;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [3:0] ref_wen(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << ref_size(f3)) - 1) << (a % 4);
    m = (m | (m >> 4)) % 16;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] d);
    longint v;
    case (f3)
      3'd0:    begin v = d % 256;   if (v >= 128)   v -= 256;   end
      3'd4:    v = d % 256;
      3'd1:    begin v = d % 65536; if (v >= 32768) v -= 65536; end
      3'd5:    v = d % 65536;
      default: v = d;
    endcase
    return v[31:0];
  endfunction

  initial begin
    logic        pend;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_d;
    logic        r_legal;
    int          hold;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;
    bus.mem_dout   = 32'h0;

    // ---- reset state
    repeat (2) tick();
    settle();
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_rdata",      bus.resp_rdata,          32'd0);
    chk("rst_err",        {31'b0, bus.resp_err},   32'd0);
    chk("rst_mem_en",     {31'b0, bus.mem_en},     32'd0);
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- SW 0x100
    drive(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    settle();
    chk("sw_mem_en",  {31'b0, bus.mem_en},       32'd1);
    chk("sw_sc",      {29'b0, bus.storecntrl_b}, 32'h4);
    chk("sw_wen",     {28'b0, bus.mem_wen},      32'hF);
    chk("sw_addr",    bus.mem_addr,              32'h100);
    chk("sw_din",     bus.mem_din,               32'hDEADBEEF);
    tick();
    bus.req_valid = 1'b0;
    settle();
    chk("sw_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("sw_rdata",      bus.resp_rdata,          32'd0);
    chk("sw_err",        {31'b0, bus.resp_err},   32'd0);
    chk("idle_mem_en",   {31'b0, bus.mem_en},     32'd0);
    tick();

    // ---- SH 0x103 then LHU 0x103
    drive(1'b1, 3'b001, 32'h103, 32'h0000A5C3);
    settle();
    chk("sh_wen", {28'b0, bus.mem_wen},      32'h9);
    chk("sh_sc",  {29'b0, bus.storecntrl_b}, 32'h2);
    tick();
    bus.req_valid = 1'b0;
    settle();
    chk("sh_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    tick();
    drive(1'b0, 3'b101, 32'h103, 32'h0);
    settle();
    chk("lhu_mem_en", {31'b0, bus.mem_en},       32'd1);
    chk("lhu_wen",    {28'b0, bus.mem_wen},      32'h0);
    chk("lhu_sc",     {29'b0, bus.storecntrl_b}, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    bus.mem_dout  = 32'h0000A5C3;
    settle();
    chk("lhu_rd_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("lhu_rd_ready", {31'b0, bus.req_ready},  32'd0);
    tick();
    bus.mem_dout = 32'h0;
    settle();
    chk("lhu_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("lhu_rdata",      bus.resp_rdata,          32'h0000A5C3);
    tick();

    // ---- LB / LBU 0x101 with byte 0x80
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h101, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      bus.mem_dout  = 32'h00000080;
      tick();
      bus.mem_dout = 32'hFFFF_FFFF;
      settle();
      chk((k == 0) ? "lb_rdata" : "lbu_rdata", bus.resp_rdata,
          (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      tick();
    end

    // ---- LW held response, then SB on release
    drive(1'b0, 3'b010, 32'h200, 32'h0);
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.mem_dout   = 32'h12345678;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.mem_dout = $urandom;
      if (k == 2) drive(1'b1, 3'b000, 32'h202, 32'h000000AB);
      settle();
      chk("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
      chk("hold_rdata", bus.resp_rdata,          32'h12345678);
      chk("hold_ready", {31'b0, bus.req_ready},  32'd0);
      chk("hold_mem_en", {31'b0, bus.mem_en},    32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    settle();
    chk("sb_ready", {31'b0, bus.req_ready},    32'd1);
    chk("sb_en",    {31'b0, bus.mem_en},       32'd1);
    chk("sb_wen",   {28'b0, bus.mem_wen},      32'h4);
    chk("sb_sc",    {29'b0, bus.storecntrl_b}, 32'h1);
    tick();
    bus.req_valid = 1'b0;
    settle();
    chk("sb_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("sb_rdata",      bus.resp_rdata,          32'd0);
    tick();

    // ---- illegal load funct3 011
    drive(1'b0, 3'b011, 32'h300, 32'h0);
    settle();
    chk("ill_mem_en", {31'b0, bus.mem_en}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    settle();
    chk("ill_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("ill_err",   {31'b0, bus.resp_err},   32'd1);
    chk("ill_rdata", bus.resp_rdata,          32'd0);
    tick();

    // ---- reset during RD
    drive(1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    bus.mem_dout  = 32'hCAFEF00D;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("arst_ready", {31'b0, bus.req_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("post_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("post_rst_en",    {31'b0, bus.mem_en},     32'd0);
      chk("post_rst_ready", {31'b0, bus.req_ready},  32'd1);
      tick();
    end

    // ---- randomized traffic against the reference rules
    pend      = 1'b0;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r_we    = $urandom_range(0, 1);
      r_f3    = $urandom_range(0, 7);
      r_a     = $urandom;
      r_d     = $urandom;
      r_legal = ref_legal(r_we, r_f3);

      if (pend) begin
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
          bus.resp_ready = 1'b0;
          bus.mem_dout   = $urandom;
          if ($urandom_range(0, 1) == 1) drive(r_we, r_f3, r_a, r_d);
          else bus.req_valid = 1'b0;
          settle();
          chk("r_hold_valid", {31'b0, bus.resp_valid}, 32'd1);
          chk("r_hold_rdata", bus.resp_rdata,          exp_rdata);
          chk("r_hold_ready", {31'b0, bus.req_ready},  32'd0);
          chk("r_hold_en",    {31'b0, bus.mem_en},     32'd0);
          tick();
        end
      end

      bus.resp_ready = 1'b1;
      drive(r_we, r_f3, r_a, r_d);
      settle();
      if (pend) begin
        chk("r_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("r_resp_rdata", bus.resp_rdata,          exp_rdata);
        chk("r_resp_err",   {31'b0, bus.resp_err},   {31'b0, exp_err});
      end
      chk("r_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("r_en",    {31'b0, bus.mem_en},    {31'b0, r_legal});
      chk("r_sc",    {29'b0, bus.storecntrl_b},
          (r_legal && r_we) ? 32'(ref_size(r_f3)) : 32'd0);
      chk("r_wen",   {28'b0, bus.mem_wen},
          (r_legal && r_we) ? {28'b0, ref_wen(r_f3, r_a)} : 32'd0);
      if (r_legal) begin
        chk("r_addr", bus.mem_addr, r_a);
        chk("r_din",  bus.mem_din,  r_d);
      end
      tick();
      bus.req_valid = 1'b0;
      bus.mem_dout  = $urandom;

      exp_err   = !r_legal;
      exp_rdata = 32'h0;
      if (r_legal && !r_we) begin
        exp_rdata = ref_ext(r_f3, bus.mem_dout);
        settle();
        chk("r_rd_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("r_rd_en",    {31'b0, bus.mem_en},     32'd0);
        tick();
        bus.mem_dout = $urandom;
      end
      pend = 1'b1;
    end

    settle();
    chk("drain_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("drain_rdata", bus.resp_rdata,          exp_rdata);
    chk("drain_err",   {31'b0, bus.resp_err},   {31'b0, exp_err});
    tick();
    settle();
    chk("final_idle", {31'b0, bus.resp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting directly upstream of the memory interface data port (port B: mem_en, mem_addr, mem_din, storecntrl_b, mem_wen, mem_dout).
- Accepts one load or store request at a time from the execute/memory pipeline stage over a valid/ready handshake.
- Drives the memory port and accounts for its 1-cycle synchronous read latency.
- Sign- or zero-extends load data and returns a registered response over a second valid/ready handshake.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- req_addr  in  32  byte address; any alignment is allowed
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3
- mem_en  out  1  port B enable
- mem_addr  out  32  port B byte address
- mem_din  out  32  port B write data, right-aligned
- storecntrl_b  out  3  001 = byte, 010 = half, 100 = word, 000 = no store
- mem_wen  out  4  physical byte-lane write mask
- mem_dout  in  32  port B read data, valid the cycle after mem_en; already rotated to logical order

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset state: state=IDLE; resp_valid=0; resp_rdata=0; resp_err=0; stored request fields cleared.
- States:
  - IDLE: no transaction in flight.
  - RD: load issued, waiting for mem_dout.
  - RESP: response held.
- req_ready = (state==IDLE) | (state==RESP & resp_ready).
- Accept = req_valid & req_ready. On accept, the memory port is driven combinationally in the same cycle:
  - mem_en=1, mem_addr=req_addr, mem_din=req_wdata.
  - For an illegal funct3, mem_en=0.
  - With no accept: mem_en=0, storecntrl_b=000, mem_wen=0000; mem_addr and mem_din are don't-care and are driven to req_* values.
- Store encoding:
  - funct3 000 -> storecntrl_b 001, logical mask 0001.
  - funct3 001 -> 010, mask 0011.
  - funct3 010 -> 100, mask 1111.
  - mem_wen = logical mask rotated left by req_addr[1:0] (4-bit rotate). Example: SH at addr[1:0]=11 -> 1001.
  - Loads drive storecntrl_b=000 and mem_wen=0000.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value is illegal: no memory access, and resp_err=1 with rdata=0.
- Transitions on accept:
  - Legal load -> RD; funct3 is latched.
  - Store or illegal request -> RESP with response fields loaded.
- RD -> RESP unconditionally next cycle. resp_rdata is loaded from mem_dout:
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
  - LW: all 32 bits.
- RESP:
  - Holds resp_valid=1 with stable rdata/err until resp_ready.
  - On resp_ready with no new accept -> IDLE.
  - On resp_ready with a simultaneous accept -> RD or RESP per the new request; the response registers are overwritten the same edge.
- Latency from accept edge to resp_valid: load 2 cycles; store or error 1 cycle.
- Throughput:
  - Back-to-back stores/errors: 1 per cycle while resp_ready=1.
  - Loads: 1 per 2 cycles.
- Misaligned and word-straddling accesses are passed through unchanged; the downstream interface performs the lane split.
- mem_dout is sampled only in RD; it is ignored otherwise.
- rst_n asserted mid-transaction: the in-flight load is abandoned and a pending response is dropped; no mem_en is issued after reset.

Decomposition:
- lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - storecntrl encodings (SC_NONE, SC_BYTE, SC_HALF, SC_WORD).
  - State enum lsu_state_t {IDLE, RD, RESP}.
- One combinational sub-module, lsu_load_extend: inputs funct3 and raw 32-bit data; output extended data.
- Store-mask rotation stays inline in the top level.

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF -> same cycle mem_en=1, storecntrl_b=100, mem_wen=1111; next cycle resp_valid=1, rdata=0, err=0.
- SH addr=0x103 data=0x0000A5C3 -> mem_wen=1001, storecntrl_b=010; then LHU 0x103 with mem_dout=0x0000A5C3 returned -> resp at accept+2, rdata=0x0000A5C3.
- LB addr=0x101, mem_dout=0x00000080 -> rdata=0xFFFFFF80; repeat with LBU -> rdata=0x00000080.
- Load with resp_ready held low 3 cycles -> resp_valid and rdata stable for those cycles and req_ready=0; release resp_ready with a new SB pending -> SB accepted on that edge, its response follows 1 cycle later.
- funct3=011 load -> mem_en=0, resp at +1 with err=1, rdata=0.
- Accept LW, assert rst_n=0 during RD -> resp_valid=0 immediately, state IDLE; after release no spurious response and req_ready=1.
